// File: rtl/matrix_operand_sequencer_if.sv
// Load handshake, MAC operand bus, capture codes and readout control of the
// symmetric matrix operand sequencer. The sequencer is the master.
interface matrix_operand_sequencer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          load_rdy;
  logic [DW-1:0] mac1_a;
  logic [DW-1:0] mac1_b;
  logic [DW-1:0] mac2_a;
  logic [DW-1:0] mac2_b;
  logic          mac_en;
  logic          mac_clr;
  logic [1:0]    mac_sel;
  logic [2:0]    input_sel1;
  logic [2:0]    input_sel2;
  logic          output_rdy;
  logic [3:0]    reg_out_sel;
  logic          done;

  modport master (
    input  din, din_valid,
    output load_rdy, mac1_a, mac1_b, mac2_a, mac2_b, mac_en, mac_clr, mac_sel,
           input_sel1, input_sel2, output_rdy, reg_out_sel, done
  );

  modport slave (
    output din, din_valid,
    input  load_rdy, mac1_a, mac1_b, mac2_a, mac2_b, mac_en, mac_clr, mac_sel,
           input_sel1, input_sel2, output_rdy, reg_out_sel, done
  );
endinterface

// File: rtl/matrix_operand_sequencer.sv
// Loads a 4x4 matrix A serially, streams operand pairs for B = A*A^T into two
// MACs, emits output-register capture codes, then sequences the readout of B.
module matrix_operand_sequencer #(
  parameter int DW      = 8,
  parameter int MAC_LAT = 1
) (
  input logic                        clk,
  input logic                        aclr,
  matrix_operand_sequencer_if.master bus
);
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, READOUT} state_t;
  typedef struct packed { logic last; logic [2:0] p; } cap_t;
  typedef struct packed { logic [1:0] i; logic [1:0] j; } pair_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [4:0]    step, step_nxt;
  logic [3:0]    rd_idx, rd_nxt;
  logic          en, en_nxt, ordy, ordy_nxt, done, done_nxt;
  logic [DW-1:0] m1a, m1b, m2a, m2b;
  logic [DW-1:0] m1a_nxt, m1b_nxt, m2a_nxt, m2b_nxt;
  logic [DW-1:0] mem [16];
  cap_t          pipe [MAC_LAT];
  cap_t          cap_in, tail;
  pair_t         pr1, pr2;
  logic          accept;

  // MAC1 takes the five off-diagonal pairs it can; MAC2 takes the diagonal plus (1,3).
  function automatic pair_t map1(input logic [2:0] p);
    case (p)
      3'd0:    return {2'd0, 2'd1};
      3'd1:    return {2'd0, 2'd2};
      3'd2:    return {2'd0, 2'd3};
      3'd3:    return {2'd1, 2'd2};
      default: return {2'd2, 2'd3};
    endcase
  endfunction

  function automatic pair_t map2(input logic [2:0] p);
    case (p)
      3'd0:    return {2'd0, 2'd0};
      3'd1:    return {2'd1, 2'd1};
      3'd2:    return {2'd2, 2'd2};
      3'd3:    return {2'd3, 2'd3};
      default: return {2'd1, 2'd3};
    endcase
  endfunction

  assign accept = (state == LOAD) && bus.din_valid;
  assign tail   = pipe[MAC_LAT-1];
  assign cap_in = '{last: en && (step[1:0] == 2'd3), p: step[4:2]};

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step;
    rd_nxt    = '0;
    en_nxt    = 1'b0;
    ordy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      LOAD: if (accept) begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_nxt = COMPUTE;
          step_nxt  = '0;
          en_nxt    = 1'b1;
        end
      end
      COMPUTE: if (step == 5'd19) begin
        state_nxt = DRAIN;
      end else begin
        step_nxt = step + 5'd1;
        en_nxt   = 1'b1;
      end
      DRAIN: if (tail.last && (tail.p == 3'd4)) begin
        state_nxt = READOUT;
        ordy_nxt  = 1'b1;
      end
      READOUT: if (rd_idx == 4'd15) begin
        state_nxt = LOAD;
        done_nxt  = 1'b1;
      end else begin
        ordy_nxt = 1'b1;
        rd_nxt   = rd_idx + 4'd1;
      end
      default: state_nxt = LOAD;
    endcase
    // Operands for the step that will be on the outputs next cycle.
    pr1     = map1(step_nxt[4:2]);
    pr2     = map2(step_nxt[4:2]);
    m1a_nxt = en_nxt ? mem[{pr1.i, step_nxt[1:0]}] : '0;
    m1b_nxt = en_nxt ? mem[{pr1.j, step_nxt[1:0]}] : '0;
    m2a_nxt = en_nxt ? mem[{pr2.i, step_nxt[1:0]}] : '0;
    m2b_nxt = en_nxt ? mem[{pr2.j, step_nxt[1:0]}] : '0;
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state  <= LOAD;
      cnt    <= '0;
      step   <= '0;
      rd_idx <= '0;
      en     <= 1'b0;
      ordy   <= 1'b0;
      done   <= 1'b0;
      m1a    <= '0;
      m1b    <= '0;
      m2a    <= '0;
      m2b    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      step   <= step_nxt;
      rd_idx <= rd_nxt;
      en     <= en_nxt;
      ordy   <= ordy_nxt;
      done   <= done_nxt;
      m1a    <= m1a_nxt;
      m1b    <= m1b_nxt;
      m2a    <= m2a_nxt;
      m2b    <= m2b_nxt;
    end
  end

  // NOTE: the element array is reset so an aborted job leaves no stale operands.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[cnt] <= bus.din;
    end
  end

  // Last-term marker travels alongside the MAC latency to time each capture.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cap_in;
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.load_rdy    = (state == LOAD);
  assign bus.mac1_a      = m1a;
  assign bus.mac1_b      = m1b;
  assign bus.mac2_a      = m2a;
  assign bus.mac2_b      = m2b;
  assign bus.mac_en      = en;
  assign bus.mac_clr     = en && (step[1:0] == 2'd0);
  assign bus.mac_sel     = en ? 2'b11 : 2'b00;
  assign bus.input_sel1  = tail.last ? tail.p : 3'b111;
  assign bus.input_sel2  = tail.last ? tail.p : 3'b111;
  assign bus.output_rdy  = ordy;
  assign bus.reg_out_sel = rd_idx;
  assign bus.done        = done;
endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Directed bench: a MAC_LAT=1 instance with a behavioural MAC pair and output
// register, plus a MAC_LAT=3 instance fed the same elements for timing checks.
module tb_matrix_operand_sequencer;
  logic clk = 1'b0;
  logic aclr;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   c0;

  localparam int RAMP_B [16] = '{30, 70, 110, 150, 70, 174, 278, 382,
                                 110, 278, 446, 614, 150, 382, 614, 846};

  matrix_operand_sequencer_if #(.DW(8)) b1 ();
  matrix_operand_sequencer_if #(.DW(8)) b3 ();
  assign b3.din       = b1.din;
  assign b3.din_valid = b1.din_valid;

  matrix_operand_sequencer #(.DW(8), .MAC_LAT(1)) dut1 (.clk(clk), .aclr(aclr), .bus(b1.master));
  matrix_operand_sequencer #(.DW(8), .MAC_LAT(3)) dut3 (.clk(clk), .aclr(aclr), .bus(b3.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MACs (one cycle latency) and symmetric output register.
  logic [19:0] acc1, acc2, dout;
  logic        dout_vld;
  logic [19:0] breg [16];

  function automatic logic [3:0] b_idx(input logic mac2, input logic [2:0] p, input logic swap);
    logic [1:0] i, j;
    case ({mac2, p})
      4'b0_000: {i, j} = {2'd0, 2'd1};
      4'b0_001: {i, j} = {2'd0, 2'd2};
      4'b0_010: {i, j} = {2'd0, 2'd3};
      4'b0_011: {i, j} = {2'd1, 2'd2};
      4'b0_100: {i, j} = {2'd2, 2'd3};
      4'b1_000: {i, j} = {2'd0, 2'd0};
      4'b1_001: {i, j} = {2'd1, 2'd1};
      4'b1_010: {i, j} = {2'd2, 2'd2};
      4'b1_011: {i, j} = {2'd3, 2'd3};
      default:  {i, j} = {2'd1, 2'd3};
    endcase
    return swap ? {j, i} : {i, j};
  endfunction

  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc1 <= '0; acc2 <= '0; dout <= '0; dout_vld <= 1'b0;
      for (int i = 0; i < 16; i++) breg[i] <= '0;
    end else begin
      if (b1.mac_en) begin
        acc1 <= (b1.mac_clr ? 20'd0 : acc1) + 20'(b1.mac1_a) * 20'(b1.mac1_b);
        acc2 <= (b1.mac_clr ? 20'd0 : acc2) + 20'(b1.mac2_a) * 20'(b1.mac2_b);
      end
      if (b1.input_sel1 != 3'b111) begin
        breg[b_idx(1'b0, b1.input_sel1, 1'b0)] <= acc1;
        breg[b_idx(1'b0, b1.input_sel1, 1'b1)] <= acc1;
      end
      if (b1.input_sel2 != 3'b111) begin
        breg[b_idx(1'b1, b1.input_sel2, 1'b0)] <= acc2;
        breg[b_idx(1'b1, b1.input_sel2, 1'b1)] <= acc2;
      end
      dout_vld <= b1.output_rdy;
      if (b1.output_rdy) dout <= breg[b1.reg_out_sel];
    end
  end

  // Event recorder, sampled mid-cycle.
  int          cap1_t[$], cap3_t[$];
  logic [2:0]  cap1_c1[$], cap1_c2[$], cap3_c[$];
  logic [19:0] rd_q[$];
  int          rdy1 = -1, rdy3 = -1, done1 = -1, done3 = -1;
  logic        ordy1_q = 1'b0, ordy3_q = 1'b0;

  always @(negedge clk) begin
    if (b1.input_sel1 != 3'b111 || b1.input_sel2 != 3'b111) begin
      cap1_t.push_back(cyc); cap1_c1.push_back(b1.input_sel1); cap1_c2.push_back(b1.input_sel2);
    end
    if (b3.input_sel1 != 3'b111) begin
      cap3_t.push_back(cyc); cap3_c.push_back(b3.input_sel1);
    end
    if (b1.output_rdy && !ordy1_q && rdy1 < 0) rdy1 = cyc;
    if (b3.output_rdy && !ordy3_q && rdy3 < 0) rdy3 = cyc;
    ordy1_q = b1.output_rdy;
    ordy3_q = b3.output_rdy;
    if (b1.done && done1 < 0) done1 = cyc;
    if (b3.done && done3 < 0) done3 = cyc;
    if (dout_vld) rd_q.push_back(dout);
  end

  task automatic clear_rec();
    cap1_t.delete(); cap1_c1.delete(); cap1_c2.delete();
    cap3_t.delete(); cap3_c.delete(); rd_q.delete();
    rdy1 = -1; rdy3 = -1; done1 = -1; done3 = -1;
  endtask

  function automatic logic [7:0] elem(input int kind, input int i);
    if (kind == 0) return (i % 5 == 0) ? 8'd1 : 8'd0;
    return 8'(i + 1);
  endfunction

  // kind 0 = identity, 1 = 1..16. Leaves the bench at the C0 negedge when gap=0, extra=0.
  task automatic load_job(input int kind, input bit gap, input int extra);
    for (int i = 0; i < 16 + extra; i++) begin
      @(negedge clk);
      b1.din       = (i < 16) ? elem(kind, i) : 8'hEE;
      b1.din_valid = 1'b1;
      if (i == 15) c0 = cyc + 1;
      if (gap) begin
        @(negedge clk);
        b1.din_valid = 1'b0;
      end
    end
    @(negedge clk);
    b1.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_rec();
    load_job(0, 1'b0, 0);
    while (cyc < c0 + 4) @(negedge clk);
    vectors++; if (b1.input_sel1 !== 3'd0) begin miscompares++; $display("FAIL pre_reset_sel1: got %0d want 0", b1.input_sel1); end
    vectors++; if (b1.mac_en !== 1'b1) begin miscompares++; $display("FAIL pre_reset_mac_en: got %0b want 1", b1.mac_en); end
    #2 aclr = 1'b1;
    #1;
    vectors++; if (b1.load_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_load_rdy: got %0b want 1", b1.load_rdy); end
    vectors++; if (b1.input_sel1 !== 3'd7) begin miscompares++; $display("FAIL rst_sel1: got %0d want 7", b1.input_sel1); end
    vectors++; if (b1.input_sel2 !== 3'd7) begin miscompares++; $display("FAIL rst_sel2: got %0d want 7", b1.input_sel2); end
    vectors++; if (b1.mac_en !== 1'b0) begin miscompares++; $display("FAIL rst_mac_en: got %0b want 0", b1.mac_en); end
    vectors++; if (b1.mac_sel !== 2'b00) begin miscompares++; $display("FAIL rst_mac_sel: got %0d want 0", b1.mac_sel); end
    vectors++; if (b1.mac_clr !== 1'b0) begin miscompares++; $display("FAIL rst_mac_clr: got %0b want 0", b1.mac_clr); end
    vectors++; if (b1.mac1_a !== 8'd0) begin miscompares++; $display("FAIL rst_mac1_a: got %0d want 0", b1.mac1_a); end
    vectors++; if (b1.output_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_output_rdy: got %0b want 0", b1.output_rdy); end
    vectors++; if (b1.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b want 0", b1.done); end
    vectors++; if (b3.load_rdy !== 1'b1 || b3.mac_en !== 1'b0) begin miscompares++; $display("FAIL rst_lat3: got load_rdy %0b mac_en %0b want 1 0", b3.load_rdy, b3.mac_en); end
    @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_identity();
    clear_rec();
    load_job(0, 1'b0, 0);
    vectors++; if (b1.mac1_a !== 8'd1) begin miscompares++; $display("FAIL id_step0_mac1_a: got %0d want 1", b1.mac1_a); end
    vectors++; if (b1.mac1_b !== 8'd0) begin miscompares++; $display("FAIL id_step0_mac1_b: got %0d want 0", b1.mac1_b); end
    vectors++; if (b1.mac2_a !== 8'd1) begin miscompares++; $display("FAIL id_step0_mac2_a: got %0d want 1", b1.mac2_a); end
    vectors++; if (b1.mac2_b !== 8'd1) begin miscompares++; $display("FAIL id_step0_mac2_b: got %0d want 1", b1.mac2_b); end
    vectors++; if (b1.mac_clr !== 1'b1 || b1.mac_sel !== 2'b11) begin miscompares++; $display("FAIL id_step0_ctrl: got clr %0b sel %0d want 1 3", b1.mac_clr, b1.mac_sel); end
    for (int i = 0; i < 60 && done1 < 0; i++) @(negedge clk);
    @(negedge clk);
    vectors++; if (done1 - c0 != 37) begin miscompares++; $display("FAIL id_done_cycle: got %0d want 37", done1 < 0 ? -1 : done1 - c0); end
    vectors++; if (cap1_t.size() < 1 || cap1_t[0] - c0 != 4 || cap1_c1[0] !== 3'd0) begin miscompares++; $display("FAIL id_cap0: got %0d captures, want code 0 at C0+4", cap1_t.size()); end
    vectors++; if (cap1_t.size() != 5 || cap1_t[4] - c0 != 20 || cap1_c1[4] !== 3'd4) begin miscompares++; $display("FAIL id_cap4: got %0d captures, want 5 with code 4 at C0+20", cap1_t.size()); end
    vectors++; if (rd_q.size() != 16) begin miscompares++; $display("FAIL id_readout_len: got %0d want 16", rd_q.size()); end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      vectors++;
      if (rd_q[i] !== ((i % 5 == 0) ? 20'd1 : 20'd0)) begin miscompares++; $display("FAIL id_dout%0d: got %0d want %0d", i, rd_q[i], (i % 5 == 0) ? 1 : 0); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ramp();
    clear_rec();
    load_job(1, 1'b0, 0);
    for (int i = 0; i < 60 && done1 < 0; i++) @(negedge clk);
    @(negedge clk);
    vectors++; if (rdy1 - c0 != 21) begin miscompares++; $display("FAIL ramp_rdy_cycle: got %0d want 21", rdy1 < 0 ? -1 : rdy1 - c0); end
    vectors++; if (done1 - c0 != 37) begin miscompares++; $display("FAIL ramp_done_cycle: got %0d want 37", done1 < 0 ? -1 : done1 - c0); end
    for (int p = 0; p < 5; p++) begin
      vectors++;
      if (p >= cap1_t.size() || cap1_t[p] - c0 != 4 * p + 4 || cap1_c1[p] !== 3'(p) || cap1_c2[p] !== 3'(p)) begin
        miscompares++;
        $display("FAIL ramp_cap%0d: got cycle %0d, want code %0d at C0+%0d", p, p < cap1_t.size() ? cap1_t[p] - c0 : -1, p, 4 * p + 4);
      end
    end
    vectors++; if (rd_q.size() != 16) begin miscompares++; $display("FAIL ramp_readout_len: got %0d want 16", rd_q.size()); end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      vectors++;
      if (rd_q[i] !== 20'(RAMP_B[i])) begin miscompares++; $display("FAIL ramp_dout%0d: got %0d want %0d", i, rd_q[i], RAMP_B[i]); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_gapped_load();
    clear_rec();
    load_job(1, 1'b1, 4);
    for (int i = 0; i < 60 && done1 < 0; i++) @(negedge clk);
    @(negedge clk);
    vectors++; if (done1 - c0 != 37) begin miscompares++; $display("FAIL gap_done_cycle: got %0d want 37", done1 < 0 ? -1 : done1 - c0); end
    vectors++; if (rd_q.size() != 16) begin miscompares++; $display("FAIL gap_readout_len: got %0d want 16", rd_q.size()); end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      vectors++;
      if (rd_q[i] !== 20'(RAMP_B[i])) begin miscompares++; $display("FAIL gap_dout%0d: got %0d want %0d", i, rd_q[i], RAMP_B[i]); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int ncap1, ncap3;
    clear_rec();
    load_job(1, 1'b0, 0);
    while (cyc < c0 + 10) @(negedge clk);
    vectors++; if (b1.mac_en !== 1'b1) begin miscompares++; $display("FAIL abort_pre_mac_en: got %0b want 1", b1.mac_en); end
    aclr = 1'b1;
    #1;
    vectors++; if (b1.mac_en !== 1'b0 || b1.load_rdy !== 1'b1 || b1.input_sel1 !== 3'd7) begin miscompares++; $display("FAIL abort_outputs: got en %0b rdy %0b sel %0d want 0 1 7", b1.mac_en, b1.load_rdy, b1.input_sel1); end
    ncap1 = cap1_t.size();
    ncap3 = cap3_t.size();
    @(negedge clk);
    aclr = 1'b0;
    repeat (30) @(negedge clk);
    vectors++; if (cap1_t.size() != ncap1 || cap3_t.size() != ncap3) begin miscompares++; $display("FAIL abort_no_capture: got %0d/%0d captures want %0d/%0d", cap1_t.size(), cap3_t.size(), ncap1, ncap3); end
    vectors++; if (rdy1 != -1 || b1.load_rdy !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got rdy_rise %0d load_rdy %0b want -1 1", rdy1, b1.load_rdy); end
    clear_rec();
    load_job(1, 1'b0, 0);
    for (int i = 0; i < 60 && done1 < 0; i++) @(negedge clk);
    @(negedge clk);
    vectors++; if (done1 - c0 != 37) begin miscompares++; $display("FAIL reload_done_cycle: got %0d want 37", done1 < 0 ? -1 : done1 - c0); end
    vectors++; if (rd_q.size() != 16) begin miscompares++; $display("FAIL reload_readout_len: got %0d want 16", rd_q.size()); end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      vectors++;
      if (rd_q[i] !== 20'(RAMP_B[i])) begin miscompares++; $display("FAIL reload_dout%0d: got %0d want %0d", i, rd_q[i], RAMP_B[i]); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mac_lat3();
    clear_rec();
    load_job(1, 1'b0, 0);
    for (int i = 0; i < 70 && done3 < 0; i++) @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      vectors++;
      if (p >= cap3_t.size() || cap3_t[p] - c0 != 4 * p + 6 || cap3_c[p] !== 3'(p)) begin
        miscompares++;
        $display("FAIL lat3_cap%0d: got cycle %0d, want code %0d at C0+%0d", p, p < cap3_t.size() ? cap3_t[p] - c0 : -1, p, 4 * p + 6);
      end
    end
    vectors++; if (rdy3 - c0 != 23) begin miscompares++; $display("FAIL lat3_rdy_cycle: got %0d want 23", rdy3 < 0 ? -1 : rdy3 - c0); end
    vectors++; if (done3 - c0 != 39) begin miscompares++; $display("FAIL lat3_done_cycle: got %0d want 39", done3 < 0 ? -1 : done3 - c0); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    aclr         = 1'b1;
    b1.din       = '0;
    b1.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    test_reset();
    test_identity();
    test_ramp();
    test_gapped_load();
    test_abort();
    test_mac_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
